// File: rtl/simple_circuit_settle_monitor_pkg.sv
// Shared state encoding and default sizing for the simple_circuit D/E capture logic.
package simple_circuit_pkg;

    localparam int unsigned STATE_W = 1;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 1'b0,
        SETTLING = 1'b1
    } state_t;

    localparam int unsigned DEF_STABLE_CYCLES = 4;
    localparam int unsigned DEF_TIMEOUT       = 64;
    localparam int unsigned DEF_CNT_W         = 8;

endpackage

// File: rtl/simple_circuit_settle_monitor_if.sv
// Launch/sample/result bus between the settle monitor and whoever drives the circuit under test.
interface simple_circuit_settle_monitor_if #(
    parameter int unsigned CNT_W = simple_circuit_pkg::DEF_CNT_W
);
    logic             launch;
    logic             d_in;
    logic             e_in;
    logic             busy;
    logic             settled;
    logic             timeout;
    logic             d_out;
    logic             e_out;
    logic [CNT_W-1:0] settle_cycles;
    logic [CNT_W-1:0] edge_count;

    modport master (
        output launch, d_in, e_in,
        input  busy, settled, timeout, d_out, e_out, settle_cycles, edge_count
    );

    modport slave (
        input  launch, d_in, e_in,
        output busy, settled, timeout, d_out, e_out, settle_cycles, edge_count
    );
endinterface

// File: rtl/simple_circuit_settle_monitor_sync2.sv
// Two-flop synchronizer for one asynchronous bit, clearing to 0 on reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/simple_circuit_settle_monitor.sv
// Samples D/E after each launch, waits for STABLE_CYCLES unchanged samples and reports
// the settled values, last-change index and edge count, or a timeout.
module simple_circuit_settle_monitor
    import simple_circuit_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned TIMEOUT       = DEF_TIMEOUT,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input logic clk,
    input logic rst,
    simple_circuit_settle_monitor_if.slave mon
);
    logic             d_sync;
    logic             e_sync;
    logic [1:0]       s;

    state_t           state;
    logic [1:0]       prev;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] elapsed;
    logic [CNT_W-1:0] edge_cnt_r;
    logic [CNT_W-1:0] last_chg;

    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] stable_nxt;
    logic [CNT_W-1:0] edge_nxt;
    logic [CNT_W-1:0] last_nxt;
    logic             changed;
    logic             hit_stable;
    logic             hit_timeout;

    sync2 u_sync_d (.clk(clk), .rst(rst), .d(mon.d_in), .q(d_sync));
    sync2 u_sync_e (.clk(clk), .rst(rst), .d(mon.e_in), .q(e_sync));

    assign s = {d_sync, e_sync};

    // Next-sample bookkeeping; a change at the timeout sample is still counted and reported.
    always_comb begin
        n          = elapsed + CNT_W'(1);
        changed    = (s != prev);
        stable_nxt = stable_cnt + CNT_W'(1);
        edge_nxt   = edge_cnt_r;
        last_nxt   = last_chg;
        if (changed) begin
            stable_nxt = '0;
            last_nxt   = n;
            if (edge_cnt_r != '1) begin
                edge_nxt = edge_cnt_r + CNT_W'(1);
            end
        end
        hit_stable  = !changed && (stable_nxt == CNT_W'(STABLE_CYCLES));
        hit_timeout = (n == CNT_W'(TIMEOUT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            prev              <= '0;
            stable_cnt        <= '0;
            elapsed           <= '0;
            edge_cnt_r        <= '0;
            last_chg          <= '0;
            mon.busy          <= 1'b0;
            mon.settled       <= 1'b0;
            mon.timeout       <= 1'b0;
            mon.d_out         <= 1'b0;
            mon.e_out         <= 1'b0;
            mon.settle_cycles <= '0;
            mon.edge_count    <= '0;
        end else begin
            mon.settled <= 1'b0;
            mon.timeout <= 1'b0;
            // Launch restarts from either state and suppresses any pulse due this cycle.
            if (mon.launch) begin
                state      <= SETTLING;
                mon.busy   <= 1'b1;
                prev       <= s;
                stable_cnt <= '0;
                elapsed    <= '0;
                edge_cnt_r <= '0;
                last_chg   <= '0;
            end else if (state == SETTLING) begin
                elapsed    <= n;
                prev       <= s;
                stable_cnt <= stable_nxt;
                edge_cnt_r <= edge_nxt;
                last_chg   <= last_nxt;
                if (hit_stable) begin
                    state             <= IDLE;
                    mon.busy          <= 1'b0;
                    mon.settled       <= 1'b1;
                    mon.d_out         <= s[1];
                    mon.e_out         <= s[0];
                    mon.settle_cycles <= last_nxt;
                    mon.edge_count    <= edge_nxt;
                end else if (hit_timeout) begin
                    state             <= IDLE;
                    mon.busy          <= 1'b0;
                    mon.timeout       <= 1'b1;
                    mon.settle_cycles <= last_nxt;
                    mon.edge_count    <= edge_nxt;
                end
            end
        end
    end
endmodule

// File: doc/simple_circuit_settle_monitor.md
# simple_circuit_settle_monitor

Clocked capture stage downstream of `Simple_Circuit_prop_delay`. It samples the circuit's asynchronous outputs D and E after each input change and waits for them to hold steady. It then reports the settled values, how long settling took, and how many intermediate transitions occurred. A timeout is reported if the outputs never settle.

## Interface
Parameters:
- `STABLE_CYCLES`, 4: consecutive unchanged samples required to declare settled; legal range 1..TIMEOUT-1.
- `TIMEOUT`, 64: cycles after launch before giving up; must be less than 2^CNT_W.
- `CNT_W`, 8: width of the `settle_cycles` and `edge_count` counters.

Ports (name, direction, width, meaning):
- `clk` input 1: sole clock; all state is updated on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `launch` input 1: one-cycle pulse meaning A/B/C were just driven with a new vector.
- `d_in` input 1: D from the circuit, asynchronous to `clk`.
- `e_in` input 1: E from the circuit, asynchronous to `clk`.
- `busy` output 1: high while in SETTLING.
- `settled` output 1: one-cycle pulse when a measurement completes.
- `timeout` output 1: one-cycle pulse when settling was abandoned.
- `d_out` output 1: last settled D value.
- `e_out` output 1: last settled E value.
- `settle_cycles` output CNT_W: elapsed-cycle index of the last observed change, or 0 if none.
- `edge_count` output CNT_W: number of sampled changes of {D,E}, saturating.

## Operation
- Synchronizer: `d_in` and `e_in` each pass through a 2-flop synchronizer. `s = {d_sync, e_sync}` is the only value the logic sees.
- States are IDLE and SETTLING. Internal registers:
  - `prev` (2 bits)
  - `stable_cnt`
  - `elapsed`
  - `edge_cnt_r`
  - `last_chg`
- IDLE, when `launch` is high:
  - go to SETTLING;
  - `prev` ← s;
  - `elapsed`, `stable_cnt`, `edge_cnt_r`, `last_chg` ← 0.
- SETTLING, every cycle without `launch`:
  - `elapsed` ← `elapsed`+1; call the new value n;
  - if s ≠ `prev`: `edge_cnt_r`+1 (saturating at 2^CNT_W−1), `stable_cnt` ← 0, `last_chg` ← n;
  - otherwise `stable_cnt` +1;
  - `prev` ← s.
  - A simultaneous change of both D and E counts as one edge.
- Settle: when `stable_cnt` would reach STABLE_CYCLES:
  - pulse `settled`;
  - load `d_out`/`e_out` ← s, `settle_cycles` ← `last_chg`, `edge_count` ← `edge_cnt_r`;
  - go to IDLE.
- Timeout: when `elapsed` would reach TIMEOUT without settling:
  - pulse `timeout`;
  - load `edge_count` and `settle_cycles` as above;
  - `d_out`/`e_out` keep their previous values;
  - go to IDLE.
- If settle and timeout occur in the same cycle, settle wins.
- `launch` while in SETTLING aborts the current measurement:
  - restart as if from IDLE;
  - no `settled` or `timeout` pulse that cycle, even if one would otherwise have fired.
- Result outputs hold their values until the next `settled` or `timeout`.
- Reset, including mid-measurement: every output goes to 0 (`busy`, `settled`, `timeout`, `d_out`, `e_out`, `settle_cycles`, `edge_count`), the state goes to IDLE, and both synchronizers clear to 0.

## Timing
- Synchronizer latency: 2 clock edges from a change on a `_in` pin to a change in s.
- `busy` rises the cycle after the edge that sampled `launch`.
- If s never changes, `settled` fires STABLE_CYCLES cycles after the `launch` edge, with `settle_cycles` = 0 and `edge_count` = 0.
- If the last change of s is seen at elapsed index k, `settled` fires at elapsed index k+STABLE_CYCLES.
- `settled` and `timeout` are registered single-cycle pulses. `busy` is low in the same cycle the pulse is high.
- A new `launch` is accepted in the same cycle as a `settled` or `timeout` pulse.

## Structure
- Shared package `simple_circuit_pkg` holds:
  - the state encoding (IDLE=0, SETTLING=1) and `STATE_W`;
  - the default STABLE_CYCLES, TIMEOUT and CNT_W.
- Sub-module `sync2`: a 2-flop synchronizer, 1 bit wide, with async active-high reset to 0. It is instantiated twice.
- Everything else stays in one module: the FSM, the counters and the result registers.

## Test plan
- Reset with `d_in`=`e_in`=1: all outputs are 0. Release reset; after 2 edges s = 2'b11, and no pulse fires.
- `launch` with D/E held at 0: `settled` fires 4 cycles later, with `d_out`=0, `e_out`=0, `settle_cycles`=0, `edge_count`=0.
- `launch`; D goes 0→1 at elapsed 3, then E glitches 0→1→0 at elapsed 5 and 6: `settled` fires at elapsed 10, with `d_out`=1, `e_out`=0, `edge_count`=3, `settle_cycles`=6.
- D toggles every 2 cycles after `launch`: `timeout` fires at elapsed 64, `d_out`/`e_out` are unchanged, `edge_count` is about 32, and `busy` falls.
- Second `launch` at elapsed 2 of a measurement: no pulse fires, and counters restart from 0. Separately, `rst` asserted mid-SETTLING: every output is 0 immediately, without waiting for a clock edge.
- `edge_count` saturation with CNT_W=3 and TIMEOUT=7, toggling every cycle: `edge_count` stops at 7 and `timeout` pulses.
